// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the LED-control UART command master.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_TIMEOUT  = 2'b01,
    ST_BAD_RESP = 2'b10
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;

  localparam logic [7:0] CMD_OFF    = 8'h00;
  localparam logic [7:0] CMD_L1     = 8'h01;
  localparam logic [7:0] CMD_L2     = 8'h02;
  localparam logic [7:0] CMD_L3     = 8'h03;
  localparam logic [7:0] CMD_L4     = 8'h04;
  localparam logic [7:0] CMD_INVERT = 8'h10;
  localparam logic [7:0] CMD_TEST   = 8'hFF;

endpackage

// File: rtl/uart_ack_timer.sv
// ACK wait timer: counts while enabled, saturates, flags the last waiting cycle.
module uart_ack_timer #(
  parameter int ACK_TIMEOUT_CLKS = 50_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int TW = $clog2(ACK_TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0] SAT  = TW'(ACK_TIMEOUT_CLKS);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)                       cnt_d = '0;
    else if (i_enable && cnt_q != SAT) cnt_d = cnt_q + TW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_master.sv
// Sends one command byte to uart_top, waits for ACK with retries, reports status.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int         ACK_TIMEOUT_CLKS = 50_000,
  parameter int         MAX_RETRIES      = 2,
  parameter logic [7:0] ACK_BYTE         = ACK_BYTE_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_byte,
  output logic       o_cmd_ready,
  output logic       o_done,
  output logic [1:0] o_status,
  output logic [7:0] o_resp_byte,
  output logic [1:0] o_attempts,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte
);

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  state_t        state_q, state_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [RW-1:0] retry_q, retry_d;
  status_t       pend_q, pend_d;
  status_t       status_q, status_d;
  logic [7:0]    resp_q, resp_d;
  logic [1:0]    attempts_q, attempts_d;
  logic          done_q, done_d;

  logic          timer_clear, timer_en, timer_expired;
  logic          fail;
  status_t       fail_code;

  uart_ack_timer #(.ACK_TIMEOUT_CLKS(ACK_TIMEOUT_CLKS)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (timer_clear),
    .i_enable  (timer_en),
    .o_expired (timer_expired)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tx_byte_d   = tx_byte_q;
    retry_d     = retry_q;
    pend_d      = pend_q;
    status_d    = status_q;
    resp_d      = resp_q;
    attempts_d  = attempts_q;
    done_d      = 1'b0;
    timer_clear = 1'b0;
    timer_en    = (state_q == S_WAIT_ACK);
    o_tx_dv     = 1'b0;
    fail        = 1'b0;
    fail_code   = ST_TIMEOUT;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          tx_byte_d = i_cmd_byte;
          retry_d   = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (!i_tx_active) begin
          o_tx_dv = 1'b1;
          state_d = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          timer_clear = 1'b1;
          state_d     = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // A received byte outranks a timeout landing on the same cycle.
        if (i_rx_dv) begin
          resp_d = i_rx_byte;
          if (i_rx_byte == ACK_BYTE) begin
            pend_d  = ST_OK;
            state_d = S_DONE;
          end else begin
            fail      = 1'b1;
            fail_code = ST_BAD_RESP;
          end
        end else if (timer_expired) begin
          fail      = 1'b1;
          fail_code = ST_TIMEOUT;
        end
        if (fail) begin
          if (32'(retry_q) < MAX_RETRIES) begin
            retry_d = retry_q + RW'(1);
            state_d = S_SEND;
          end else begin
            pend_d  = fail_code;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d     = 1'b1;
        status_d   = pend_q;
        attempts_d = 2'(32'(retry_q) + 1);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      tx_byte_q  <= '0;
      retry_q    <= '0;
      pend_q     <= ST_OK;
      status_q   <= ST_OK;
      resp_q     <= '0;
      attempts_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      retry_q    <= retry_d;
      pend_q     <= pend_d;
      status_q   <= status_d;
      resp_q     <= resp_d;
      attempts_q <= attempts_d;
      done_q     <= done_d;
    end
  end

  // o_tx_dv is decoded from state, so the async reset kills the strobe at once.
  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_done      = done_q;
  assign o_status    = status_q;
  assign o_resp_byte = resp_q;
  assign o_attempts  = attempts_q;
  assign o_tx_byte   = tx_byte_q;

endmodule
